fwd_hazard_unit_mc: RTL

- Parametrised next-generation forwarding and hazard unit for the 5-stage RISC-V pipeline with a multi-cycle multiplier in EX.
- Generalises operand forwarding to N_SRC source operands and adds a multiplier-result forward source.
- Adds a sequential scoreboard that tracks one in-flight multiply. From it the unit raises pipeline stalls for RAW/WAW dependences, load-use hazards and a second multiply issued while the first is busy.

---
 rtl/fwd_hazard_unit_mc.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit_mc.sv
// Forwarding and hazard unit for a 5-stage pipeline with a multi-cycle multiplier in EX.
// A small scoreboard tracks one in-flight multiply and feeds operand selects and stalls.
module fwd_hazard_unit_mc #(
  parameter int REG_W   = 5,
  parameter int N_SRC   = 2,
  parameter int MUL_LAT = 3
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic [N_SRC*REG_W-1:0] rs_id_ex,
  input  logic [REG_W-1:0]       rd_ex_mem,
  input  logic                   regwrite_ex_mem,
  input  logic [REG_W-1:0]       rd_mem_wb,
  input  logic                   regwrite_mem_wb,
  input  logic                   memread_id_ex,
  input  logic [REG_W-1:0]       rd_id_ex,
  input  logic                   mul_start,
  input  logic [N_SRC*REG_W-1:0] rs_if_id,
  input  logic [REG_W-1:0]       rd_if_id,
  input  logic                   regwrite_if_id,
  input  logic                   is_mul_if_id,
  output logic [2*N_SRC-1:0]     fwd_sel,
  output logic                   stall,
  output logic                   mul_busy,
  output logic                   mul_wb,
  output logic                   err
);

  localparam int CNT_W = $clog2(MUL_LAT);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 2);
  localparam logic LAT_GT2 = (MUL_LAT > 2) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [REG_W-1:0]   pend_rd_r;
  logic               err_r;

  logic               busy_s;
  logic               done_s;
  logic [2*N_SRC-1:0] fwd_sel_s;
  logic               stall_s;

  assign busy_s = (state_r == ST_BUSY);
  assign done_s = (state_r == ST_DONE);

  // Multiply scoreboard: one outstanding result, a new issue in DONE chains without an idle gap.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      pend_rd_r <= '0;
      err_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (mul_start) begin
            state_r   <= ST_BUSY;
            cnt_r     <= CNT_INIT;
            pend_rd_r <= rd_id_ex;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (mul_start) begin
            err_r <= 1'b1;
          end else begin
            err_r <= err_r;
          end
          if (cnt_r == '0) begin
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Operand selects and stall request; forced quiet while reset is asserted.
  always_comb begin
    logic [REG_W-1:0] rs_v;
    logic             hit_v;
    fwd_sel_s = '0;
    stall_s   = 1'b0;
    rs_v      = '0;
    hit_v     = 1'b0;
    if (arst_n) begin
      for (int i = 0; i < N_SRC; i++) begin
        rs_v = rs_id_ex[i*REG_W +: REG_W];
        if (rs_v == '0) begin
          fwd_sel_s[2*i +: 2] = 2'b00;
        end else if (done_s && (pend_rd_r == rs_v)) begin
          fwd_sel_s[2*i +: 2] = 2'b11;
        end else if (regwrite_ex_mem && (rd_ex_mem == rs_v)) begin
          fwd_sel_s[2*i +: 2] = 2'b10;
        end else if (regwrite_mem_wb && (rd_mem_wb == rs_v)) begin
          fwd_sel_s[2*i +: 2] = 2'b01;
        end else begin
          fwd_sel_s[2*i +: 2] = 2'b00;
        end
      end
      // Load-use and multiply RAW against every ID-stage source.
      for (int i = 0; i < N_SRC; i++) begin
        rs_v  = rs_if_id[i*REG_W +: REG_W];
        hit_v = (rs_v != '0) &&
                ((memread_id_ex && (rd_id_ex == rs_v)) ||
                 (busy_s && (pend_rd_r == rs_v)) ||
                 (mul_start && (rd_id_ex == rs_v)));
        stall_s = stall_s | hit_v;
      end
      stall_s = stall_s |
                (regwrite_if_id && (rd_if_id != '0) &&
                 ((busy_s && (rd_if_id == pend_rd_r)) ||
                  (mul_start && (rd_if_id == rd_id_ex)))) |
                (is_mul_if_id && (busy_s || (mul_start && LAT_GT2)));
    end else begin
      fwd_sel_s = '0;
      stall_s   = 1'b0;
    end
  end

  assign fwd_sel  = fwd_sel_s;
  assign stall    = stall_s;
  assign mul_busy = (state_r != ST_IDLE);
  assign mul_wb   = done_s;
  assign err      = err_r;

endmodule
